// File: rtl/tl_phase_sched.sv
// Timed eight-phase intersection scheduler with protected left turns.
// Greens gap-out or max-out after a minimum; yellows run a fixed time.
module tl_phase_sched #(
    parameter int YEL_CYC = 3,
    parameter int MIN_GRN = 4,
    parameter int MAX_GRN = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       Tal,
    input  logic       Tbl,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S0, S1, S2, S3, S4, S5, S6, S7
    } st_t;

    localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GRN - 1);
    localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GRN - 1);
    localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YEL_CYC - 1);

    localparam logic [1:0] GRN = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] RED = 2'b10;
    localparam logic [1:0] ARW = 2'b11;

    st_t             st_q;
    st_t             st_d;
    logic [CNT_W-1:0] cnt;
    logic            al_pend;
    logic            bl_pend;
    logic            sens;
    logic            grn_exit;
    logic            yel_exit;

    always_comb begin
        sens = 1'b0;
        unique case (st_q)
            S0:      sens = Ta;
            S2:      sens = Tal;
            S4:      sens = Tb;
            S6:      sens = Tbl;
            default: sens = 1'b0;
        endcase
    end

    assign grn_exit = (cnt >= MIN_M1) && (!sens || cnt == MAX_M1);
    assign yel_exit = (cnt == YEL_M1);

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            S0: if (grn_exit) st_d = S1;
            S1: if (yel_exit) st_d = (al_pend | Tal) ? S2 : S4;
            S2: if (grn_exit) st_d = S3;
            S3: if (yel_exit) st_d = S4;
            S4: if (grn_exit) st_d = S5;
            S5: if (yel_exit) st_d = (bl_pend | Tbl) ? S6 : S0;
            S6: if (grn_exit) st_d = S7;
            S7: if (yel_exit) st_d = S0;
            default: st_d = S0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q    <= S0;
            cnt     <= '0;
            al_pend <= 1'b0;
            bl_pend <= 1'b0;
        end else begin
            st_q    <= st_d;
            al_pend <= (st_q == S2) ? 1'b0 : (al_pend | Tal);
            bl_pend <= (st_q == S6) ? 1'b0 : (bl_pend | Tbl);
            // timer restarts on every phase change, saturates otherwise
            if (st_d != st_q)
                cnt <= '0;
            else if (cnt != {CNT_W{1'b1}})
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        La = RED;
        Lb = RED;
        unique case (st_q)
            S0: La = GRN;
            S1: La = YEL;
            S2: La = ARW;
            S3: La = YEL;
            S4: Lb = GRN;
            S5: Lb = YEL;
            S6: Lb = ARW;
            S7: Lb = YEL;
            default: begin
                La = RED;
                Lb = RED;
            end
        endcase
    end

    assign state = st_q;

endmodule

// File: tb/tb_tl_phase_sched.sv
// Scoreboard bench for tl_phase_sched: a cycle model predicts each
// state/light word, plus directed phase-length and request checks.
module tb_tl_phase_sched;

    localparam int YEL = 3;
    localparam int MING = 4;
    localparam int MAXG = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       Ta = 1'b0;
    logic       Tb = 1'b0;
    logic       Tal = 1'b0;
    logic       Tbl = 1'b0;
    logic [1:0] La;
    logic [1:0] Lb;
    logic [2:0] state;

    tl_phase_sched #(
        .YEL_CYC(YEL),
        .MIN_GRN(MING),
        .MAX_GRN(MAXG),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .Ta(Ta),
        .Tb(Tb),
        .Tal(Tal),
        .Tbl(Tbl),
        .La(La),
        .Lb(Lb),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int la;
        int lb;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int m_st, m_cnt;
    bit m_al, m_bl;

    int cur, len, last_len;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int la_of(input int s);
        case (s)
            0: return 0;
            1, 3: return 1;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int lb_of(input int s);
        case (s)
            4: return 0;
            5, 7: return 1;
            6: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic model_reset();
        m_st = 0;
        m_cnt = 0;
        m_al = 0;
        m_bl = 0;
        q.delete();
        cur = 0;
        len = 1;
    endtask

    // one clock edge of the reference behaviour
    task automatic model_step();
        bit sn[4];
        int nx;
        sn = '{Ta, Tal, Tb, Tbl};
        nx = m_st;
        if (m_st % 2 == 0) begin
            if (m_cnt >= MING - 1 &&
                (!sn[m_st / 2] || m_cnt == MAXG - 1))
                nx = m_st + 1;
        end else if (m_cnt == YEL - 1) begin
            case (m_st)
                1: nx = (m_al || Tal) ? 2 : 4;
                3: nx = 4;
                5: nx = (m_bl || Tbl) ? 6 : 0;
                default: nx = 0;
            endcase
        end
        m_al = (m_st == 2) ? 1'b0 : (m_al | Tal);
        m_bl = (m_st == 6) ? 1'b0 : (m_bl | Tbl);
        m_cnt = (nx != m_st) ? 0 : ((m_cnt < 31) ? m_cnt + 1 : 31);
        m_st = nx;
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        model_step();
        q.push_back('{m_st, la_of(m_st), lb_of(m_st)});
        #1;
        e = q.pop_front();
        chk("state", int'(state), e.st);
        chk("La", int'(La), e.la);
        chk("Lb", int'(Lb), e.lb);
        chk("one_red", int'(La == 2'b10 || Lb == 2'b10), 1);
        if (int'(state) == cur) begin
            len++;
        end else begin
            if (cur % 2 == 0)
                chk("grn_len", int'(len >= MING && len <= MAXG), 1);
            else
                chk("yel_len", len, YEL);
            last_len = len;
            cur = int'(state);
            len = 1;
        end
    endtask

    task automatic wait_st(input int s);
        int n = 0;
        while (int'(state) != s && n < 80) begin
            cyc();
            n++;
        end
        if (int'(state) != s) chk("wait_timeout", int'(state), s);
    endtask

    task automatic wait_leave(input int s);
        int n = 0;
        while (int'(state) == s && n < 80) begin
            cyc();
            n++;
        end
        if (int'(state) == s) chk("leave_timeout", int'(state), -1);
    endtask

    // async reset pulse between edges; outputs must snap to S0 at once
    task automatic pulse_reset(input string tag);
        reset_n = 1'b0;
        #1;
        chk({tag, "_st"}, int'(state), 0);
        chk({tag, "_La"}, int'(La), 0);
        chk({tag, "_Lb"}, int'(Lb), 2);
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        last_len = 0;
        #3;
        chk("rst_st", int'(state), 0);
        chk("rst_La", int'(La), 0);
        chk("rst_Lb", int'(Lb), 2);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();

        // idle loop: S0 4, S1 3, S4 4, S5 3
        for (int i = 0; i < 28; i++) cyc();

        // max-out on held Ta
        Ta = 1'b1;
        wait_st(4);
        wait_st(0);
        wait_st(1);
        chk("maxout_len", last_len, 16);

        // gap-out at cnt=6
        wait_st(4);
        wait_st(0);
        for (int i = 0; i < 6; i++) cyc();
        Ta = 1'b0;
        cyc();
        chk("gap_state", int'(state), 1);
        chk("gap_len", last_len, 7);

        // one-cycle Tal pulse in S4 is remembered
        wait_st(4);
        cyc();
        Tal = 1'b1;
        cyc();
        Tal = 1'b0;
        wait_st(0);
        wait_st(1);
        wait_leave(1);
        chk("al_to_s2", int'(state), 2);
        chk("al_arrow", int'(La), 3);
        wait_leave(2);
        chk("s2_len", last_len, 4);
        chk("s2_to_s3", int'(state), 3);
        wait_leave(3);
        chk("s3_len", last_len, 3);
        chk("s3_to_s4", int'(state), 4);
        wait_st(1);
        wait_leave(1);
        chk("al_cleared", int'(state), 4);

        // Tal only on the decision cycle of S1
        wait_st(1);
        cyc();
        cyc();
        Tal = 1'b1;
        cyc();
        Tal = 1'b0;
        chk("late_tal", int'(state), 2);

        // Tbl held through S6 -> max-out
        Tbl = 1'b1;
        wait_st(6);
        wait_leave(6);
        chk("s6_len", last_len, 16);
        chk("s6_to_s7", int'(state), 7);
        Tbl = 1'b0;
        wait_leave(7);
        chk("s7_to_s0", int'(state), 0);

        // reset in S2 with a pending left request
        Tal = 1'b1;
        wait_st(2);
        Tal = 1'b0;
        pulse_reset("mid_rst");
        wait_leave(0);
        chk("post_rst_s0", last_len, 4);
        wait_leave(1);
        chk("post_rst_s4", int'(state), 4);

        // random sensors
        for (int i = 0; i < 2000; i++) begin
            Ta  = ($urandom_range(0, 3) != 0);
            Tb  = ($urandom_range(0, 3) != 0);
            Tal = ($urandom_range(0, 15) == 0);
            Tbl = ($urandom_range(0, 15) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
